alu_rr_arbiter: RTL and testbench



---
 rtl/alu_rr_arbiter.sv | 166 ++++++++++++++++
 tb/tb_alu_rr_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: shares one external combinational 4-bit ALU among NREQ
// requesters. A round-robin grant captures one operation, the ALU is fed from
// registered operands, and the result comes back through a one-entry
// response buffer with backpressure.
// Optional build macro: ALU_ARB_STATS_EN adds stat_clr/stat_ops/stat_stall.
//
//   state | meaning
//   IDLE  | looking for a requester; req_ready pulses for the grant
//   EXEC  | latched operands drive the ALU; result is captured on this edge
//   RESP  | response held in the buffer until rsp_ready
module alu_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [4*NREQ-1:0] req_in1,
  input  logic [4*NREQ-1:0] req_in2,
  input  logic [3*NREQ-1:0] req_op,
  output logic [3:0]        alu_in1,
  output logic [3:0]        alu_in2,
  output logic [2:0]        alu_opcode,
  input  logic [3:0]        alu_out,
  input  logic [3:0]        alu_flags,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [3:0]        rsp_out,
  output logic [3:0]        rsp_flags
`ifdef ALU_ARB_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [15:0]       stat_ops,
  output logic [15:0]       stat_stall
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [IDW-1:0] r_rr_ptr;
  logic [3:0]     r_in1;
  logic [3:0]     r_in2;
  logic [2:0]     r_op;
  logic [IDW-1:0] r_id;
  logic           r_rsp_valid;
  logic [IDW-1:0] r_rsp_id;
  logic [3:0]     r_rsp_out;
  logic [3:0]     r_rsp_flags;

  logic           w_found;
  logic [IDW-1:0] w_grant;
  logic           w_accept;
  logic [3:0]     w_sel_in1;
  logic [3:0]     w_sel_in2;
  logic [2:0]     w_sel_op;

  // Round-robin search starting one past the last grant, wrapping at NREQ.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!w_found && req_valid[(int'(r_rr_ptr) + k) % NREQ]) begin
        w_found = 1'b1;
        w_grant = IDW'((int'(r_rr_ptr) + k) % NREQ);
      end
    end
  end

  // Grant is only offered in IDLE and never while reset is asserted.
  always_comb begin
    w_accept  = rst_n && (r_state == S_IDLE) && w_found;
    req_ready = w_accept ? (NREQ'(1) << w_grant) : '0;
    w_sel_in1 = req_in1[4*int'(w_grant) +: 4];
    w_sel_in2 = req_in2[4*int'(w_grant) +: 4];
    w_sel_op  = req_op[3*int'(w_grant) +: 3];
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // FSM next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_next = S_EXEC;
      S_EXEC:  w_next = S_RESP;
      S_RESP:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand capture on grant, result capture in EXEC, response release in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= IDW'(NREQ - 1);
      r_in1       <= '0;
      r_in2       <= '0;
      r_op        <= '0;
      r_id        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_out   <= '0;
      r_rsp_flags <= '0;
    end else begin
      if (w_accept) begin
        r_in1    <= w_sel_in1;
        r_in2    <= w_sel_in2;
        r_op     <= w_sel_op;
        r_id     <= w_grant;
        r_rr_ptr <= w_grant;
      end
      if (r_state == S_EXEC) begin
        r_rsp_out   <= alu_out;
        r_rsp_flags <= alu_flags;
        r_rsp_id    <= r_id;
        r_rsp_valid <= 1'b1;
      end else if (r_state == S_RESP && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign alu_in1    = r_in1;
  assign alu_in2    = r_in2;
  assign alu_opcode = r_op;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_out    = r_rsp_out;
  assign rsp_flags  = r_rsp_flags;

`ifdef ALU_ARB_STATS_EN
  logic [15:0] r_stat_ops;
  logic [15:0] r_stat_stall;

  // Saturating activity counters; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_ops   <= '0;
      r_stat_stall <= '0;
    end else if (stat_clr) begin
      r_stat_ops   <= '0;
      r_stat_stall <= '0;
    end else begin
      if (w_accept && r_stat_ops != 16'hFFFF)
        r_stat_ops <= r_stat_ops + 16'd1;
      if (r_rsp_valid && !rsp_ready && r_stat_stall != 16'hFFFF)
        r_stat_stall <= r_stat_stall + 16'd1;
    end
  end

  assign stat_ops   = r_stat_ops;
  assign stat_stall = r_stat_stall;
`endif

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter with a behavioural ALU on the shared port.
module tb_alu_rr_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [4*NREQ-1:0] req_in1;
  logic [4*NREQ-1:0] req_in2;
  logic [3*NREQ-1:0] req_op;
  logic [3:0]        alu_in1;
  logic [3:0]        alu_in2;
  logic [2:0]        alu_opcode;
  logic [3:0]        alu_out;
  logic [3:0]        alu_flags;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [3:0]        rsp_out;
  logic [3:0]        rsp_flags;
`ifdef ALU_ARB_STATS_EN
  logic              stat_clr;
  logic [15:0]       stat_ops;
  logic [15:0]       stat_stall;
`endif

  int n_tot;
  int n_bad;

  alu_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_in1    (req_in1),
    .req_in2    (req_in2),
    .req_op     (req_op),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .alu_opcode (alu_opcode),
    .alu_out    (alu_out),
    .alu_flags  (alu_flags),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_out    (rsp_out),
    .rsp_flags  (rsp_flags)
`ifdef ALU_ARB_STATS_EN
    ,
    .stat_clr   (stat_clr),
    .stat_ops   (stat_ops),
    .stat_stall (stat_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stand-in for the external ALU: flags {neg, zero, ovf, carry}.
  always_comb begin
    logic [4:0] w_wide;
    logic       w_c;
    logic       w_v;
    w_wide = '0;
    w_c    = 1'b0;
    w_v    = 1'b0;
    case (alu_opcode)
      3'b000: begin
        w_wide = {1'b0, alu_in1} + {1'b0, alu_in2};
        w_c    = w_wide[4];
        w_v    = (alu_in1[3] == alu_in2[3]) && (w_wide[3] != alu_in1[3]);
      end
      3'b001: begin
        w_wide = {1'b0, alu_in1} - {1'b0, alu_in2};
        w_c    = ~w_wide[4];
        w_v    = (alu_in1[3] != alu_in2[3]) && (w_wide[3] != alu_in1[3]);
      end
      3'b010:  w_wide = {1'b0, alu_in1 & alu_in2};
      3'b011:  w_wide = {1'b0, alu_in1 | alu_in2};
      3'b100:  w_wide = {1'b0, ~alu_in1};
      3'b101:  w_wide = {1'b0, alu_in1 ^ alu_in2};
      3'b110:  w_wide = {1'b0, 4'd0 - alu_in2};
      default: w_wide = {1'b0, alu_in2[2:0], 1'b0};
    endcase
    alu_out   = w_wide[3:0];
    alu_flags = {w_wide[3], (w_wide[3:0] == 4'd0), w_v, w_c};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Holds reset for two cycles and releases it on a falling edge.
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int         ng;
  int         g_cyc[5];
  logic [3:0] g_rdy[5];

  initial begin
    n_tot     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_in1   = '0;
    req_in2   = '0;
    req_op    = '0;
    rsp_ready = 1'b1;
`ifdef ALU_ARB_STATS_EN
    stat_clr  = 1'b0;
`endif
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_alu_in1", alu_in1, 0);
    chk("rst_rsp_id", rsp_id, 0);
    do_reset();

    // Requester 0: 0101 + 0011.
    @(negedge clk);
    req_in1[3:0] = 4'b0101; req_in2[3:0] = 4'b0011; req_op[2:0] = 3'b000;
    req_valid = 4'b0001;
    #1 chk("add_ready", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    chk("add_ready_drop", req_ready, 0);
    chk("add_alu_in1", alu_in1, 4'b0101);
    chk("add_alu_in2", alu_in2, 4'b0011);
    chk("add_alu_op", alu_opcode, 3'b000);
    chk("add_rsp_early", rsp_valid, 0);
    @(negedge clk); #1;
    chk("add_rsp_valid", rsp_valid, 1);
    chk("add_rsp_out", rsp_out, 4'b1000);
    chk("add_rsp_flags", rsp_flags, 4'b1010);
    chk("add_rsp_id", rsp_id, 0);
    @(negedge clk); #1;
    chk("add_rsp_drop", rsp_valid, 0);
    chk("add_alu_hold", alu_in1, 4'b0101);

    // Requester 2: 0011 - 0011.
    @(negedge clk);
    req_in1[11:8] = 4'b0011; req_in2[11:8] = 4'b0011; req_op[8:6] = 3'b001;
    req_valid = 4'b0100;
    #1 chk("sub_ready", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk); #1;
    chk("sub_rsp_valid", rsp_valid, 1);
    chk("sub_rsp_out", rsp_out, 4'b0000);
    chk("sub_rsp_flags", rsp_flags, 4'b0101);
    chk("sub_rsp_id", rsp_id, 2);
    @(negedge clk);

    // All requesters valid from reset: grants rotate 0,1,2,3,0, 3 cycles apart.
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    do_reset();
    ng = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      #1;
      if (req_ready != 0 && ng < 5) begin
        g_rdy[ng] = req_ready;
        g_cyc[ng] = cyc;
        ng++;
      end
      @(negedge clk);
    end
    chk("rr_count", ng, 5);
    if (ng == 5) begin
      chk("rr_g0", g_rdy[0], 4'b0001);
      chk("rr_g1", g_rdy[1], 4'b0010);
      chk("rr_g2", g_rdy[2], 4'b0100);
      chk("rr_g3", g_rdy[3], 4'b1000);
      chk("rr_g4", g_rdy[4], 4'b0001);
      for (int i = 1; i < 5; i++) chk("rr_spacing", g_cyc[i] - g_cyc[i-1], 3);
    end

    // Backpressure: requester 1 OR, requester 3 waits behind it.
    req_valid = 4'b1010;
    rsp_ready = 1'b0;
    req_in1[7:4] = 4'b1010;  req_in2[7:4] = 4'b0101;  req_op[5:3] = 3'b011;
    req_in1[15:12] = 4'b0000; req_in2[15:12] = 4'b0110; req_op[11:9] = 3'b111;
    do_reset();
    #1 chk("bp_ready1", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = 4'b1000;
    #1 chk("bp_exec_ready", req_ready, 0);
    @(negedge clk); #1;
    chk("bp_rsp_valid", rsp_valid, 1);
    chk("bp_rsp_out", rsp_out, 4'b1111);
    chk("bp_rsp_flags", rsp_flags, 4'b1000);
    chk("bp_rsp_id", rsp_id, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_out", rsp_out, 4'b1111);
      chk("bp_hold_id", rsp_id, 1);
      chk("bp_hold_ready", req_ready, 0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    chk("bp_pre_hs_valid", rsp_valid, 1);
    chk("bp_pre_hs_ready", req_ready, 0);
    @(negedge clk); #1;
    chk("bp_post_hs_valid", rsp_valid, 0);
    chk("bp_next_ready", req_ready, 4'b1000);
    @(negedge clk);
    req_valid = 4'b0000;
    #1 chk("bp_next_exec", req_ready, 0);
    @(negedge clk); #1;
    chk("bp_shl_out", rsp_out, 4'b1100);
    chk("bp_shl_id", rsp_id, 3);
    @(negedge clk);

    // Reset during EXEC discards the op and restores requester-0 priority.
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    do_reset();
    #1 chk("mid_ready2", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = 4'b0101;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_alu_in1", alu_in1, 0);
    @(negedge clk);
    #1 chk("mid_rst_hold", rsp_valid, 0);
    rst_n = 1'b1;
    #1 chk("mid_first_grant", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = 4'b0000;
    #1 chk("mid_exec_valid", rsp_valid, 0);
    @(negedge clk); #1;
    chk("mid_rsp_valid", rsp_valid, 1);
    chk("mid_rsp_id", rsp_id, 0);
    @(negedge clk);

`ifdef ALU_ARB_STATS_EN
    // Three ops back to back; the third stalls for two cycles.
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    do_reset();
    repeat (7) @(negedge clk);
    req_valid = 4'b0000;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    chk("stat_ops", stat_ops, 3);
    chk("stat_stall", stat_stall, 2);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    #1;
    chk("stat_ops_clr", stat_ops, 0);
    chk("stat_stall_clr", stat_stall, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
